// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter:
// arbiter state encoding, default bus widths and requester indices.
package ram_arb_pkg;

  // Default RAM geometry (256 x 8 data RAM).
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Requester indices: r0 is the CPU datapath, r1 the external loader/debug port.
  localparam int REQ_CPU = 0;
  localparam int REQ_EXT = 1;

  // Arbiter FSM states. GNTK means requester K currently owns the RAM port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Grant state belonging to a requester index.
  function automatic arb_state_e gnt_state_of(input logic idx);
    return idx ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 256x8 data RAM between the CPU datapath (r0)
// and an external loader/debug port (r1).
//
// Valid/ready semantics: a requester raises rK_req with rK_we/rK_addr/rK_wdata
// and holds all of them stable; the access happens (handshake) in exactly the
// cycle where rK_req && rK_gnt, one access per handshake cycle. Writes drive the
// RAM write port combinationally in that cycle; reads present the address in that
// cycle and return registered data with a one-cycle rK_rvalid pulse next cycle.
//
// A tenure lasts up to MAX_BURST handshakes while the other requester waits; with
// no competitor a tenure is unlimited. Switching owners costs no idle cycle.
//
// Optional build macro ARB_WP_EN: r1 writes below PROT_LIMIT still handshake but
// are not written to the RAM, and r1_err pulses one cycle after the handshake.
// Without the macro there is no suppression and r1_err is tied low.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                 ADDR_W     = ADDR_W_DEF,
  parameter int                 DATA_W     = DATA_W_DEF,
  parameter int                 MAX_BURST  = 4,
  parameter logic [ADDR_W-1:0]  PROT_LIMIT = 'h10
) (
  input  logic              clock_write,
  input  logic              reset,
  // requester 0 (CPU datapath)
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  // requester 1 (external loader/debug port)
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  // RAM ports
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_write,
  output logic [DATA_W-1:0] ram_data_write,
  output logic [ADDR_W-1:0] ram_addr_read,
  input  logic [DATA_W-1:0] ram_data_read,
  // debug: current arbiter state
  output arb_state_e        state_o
);

  // Burst counter value at which a waiting competitor takes over.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_e  state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic        last_q, last_d;

  logic        hs0, hs1;
  logic        enter_gnt;
  logic        r1_prot;
  logic        r1_wr_block;

  logic              r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;

  // r1 address falls inside the protected low region.
  assign r1_prot = (r1_addr < PROT_LIMIT);

`ifdef ARB_WP_EN
  logic r1_err_q;
  // r1 write handshakes into the protected region are swallowed.
  assign r1_wr_block = hs1 && r1_we && r1_prot;
`else
  logic unused_prot;
  assign unused_prot = r1_prot;
  assign r1_wr_block = 1'b0;
`endif

  // State register: synchronous active-high reset returns to IDLE.
  always_ff @(posedge clock_write) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: round-robin on ties, bounded burst while the other waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (r0_req && r1_req) begin
          state_d = gnt_state_of(~last_q);
        end else if (r0_req) begin
          state_d = GNT0;
        end else if (r1_req) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!r0_req) begin
          state_d = r1_req ? GNT1 : IDLE;
        end else if (r1_req && (burst_q == BURST_LAST)) begin
          state_d = GNT1;
        end
      end
      GNT1: begin
        if (!r1_req) begin
          state_d = r0_req ? GNT0 : IDLE;
        end else if (r0_req && (burst_q == BURST_LAST)) begin
          state_d = GNT0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: grants, handshake detection and the RAM port muxes.
  always_comb begin
    r0_gnt         = (state_q == GNT0);
    r1_gnt         = (state_q == GNT1);
    // A handshake in the reset cycle is dropped: no write, no read return.
    hs0            = r0_gnt && r0_req && !reset;
    hs1            = r1_gnt && r1_req && !reset;
    ram_we         = (hs0 && r0_we) || (hs1 && r1_we && !r1_wr_block);
    // r0 addresses the RAM whenever r1 is not handshaking.
    ram_addr_write = hs1 ? r1_addr  : r0_addr;
    ram_data_write = hs1 ? r1_wdata : r0_wdata;
    ram_addr_read  = hs1 ? r1_addr  : r0_addr;
    state_o        = state_q;
  end

  // Tenure bookkeeping: restart the burst count and remember the owner on entry.
  always_comb begin
    burst_d   = burst_q;
    last_d    = last_q;
    enter_gnt = (state_d != state_q) && (state_d != IDLE);
    if (enter_gnt) begin
      burst_d = 4'd0;
      last_d  = (state_d == GNT1);
    end else if ((hs0 || hs1) && (burst_q != BURST_LAST)) begin
      burst_d = burst_q + 4'd1;
    end
  end

  // Burst counter and last-owner registers; last resets to r1 so r0 wins the first tie.
  always_ff @(posedge clock_write) begin
    if (reset) begin
      burst_q <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Read return path: capture asynchronous RAM data at the read handshake edge.
  always_ff @(posedge clock_write) begin
    if (reset) begin
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      r0_rvalid_q <= hs0 && !r0_we;
      r1_rvalid_q <= hs1 && !r1_we;
      if (hs0 && !r0_we) begin
        r0_rdata_q <= ram_data_read;
      end
      if (hs1 && !r1_we) begin
        r1_rdata_q <= ram_data_read;
      end
    end
  end

`ifdef ARB_WP_EN
  // Protection error pulse, one cycle after the blocked r1 write handshake.
  always_ff @(posedge clock_write) begin
    if (reset) begin
      r1_err_q <= 1'b0;
    end else begin
      r1_err_q <= r1_wr_block;
    end
  end
  assign r1_err = r1_err_q;
`else
  assign r1_err = 1'b0;
`endif

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (tenure owner, handshake count,
// reference memory and per-requester read-data queues).
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int         MB   = 4;
  localparam logic [7:0] PROT = 8'h10;
`ifdef ARB_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock_write;
  logic reset;
  logic init_en;

  initial clock_write = 1'b0;
  always #5 clock_write = ~clock_write;

  // ---------------- DUT ----------------
  logic       r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [7:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;
  logic       ram_we;
  logic [7:0] ram_addr_write, ram_data_write, ram_addr_read, ram_data_read;
  arb_state_e state_o;

  ram_port_arbiter dut (
    .clock_write    (clock_write),
    .reset          (reset),
    .r0_req         (r0_req),
    .r0_we          (r0_we),
    .r0_addr        (r0_addr),
    .r0_wdata       (r0_wdata),
    .r0_gnt         (r0_gnt),
    .r0_rvalid      (r0_rvalid),
    .r0_rdata       (r0_rdata),
    .r1_req         (r1_req),
    .r1_we          (r1_we),
    .r1_addr        (r1_addr),
    .r1_wdata       (r1_wdata),
    .r1_gnt         (r1_gnt),
    .r1_rvalid      (r1_rvalid),
    .r1_rdata       (r1_rdata),
    .r1_err         (r1_err),
    .ram_we         (ram_we),
    .ram_addr_write (ram_addr_write),
    .ram_data_write (ram_data_write),
    .ram_addr_read  (ram_addr_read),
    .ram_data_read  (ram_data_read),
    .state_o        (state_o)
  );

  // ---------------- environment RAM (256x8, async read) ----------------
  function automatic logic [7:0] init_val(input logic [7:0] a);
    logic [7:0] v;
    v = 8'(a * 8'd37 + 8'd11);
    if (a == 8'h05) v = 8'h3C;
    return v;
  endfunction

  logic [7:0] ram [256];
  int we_count = 0;

  assign ram_data_read = ram[ram_addr_read];

  always @(posedge clock_write) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
    end else if (ram_we) begin
      ram[ram_addr_write] <= ram_data_write;
      we_count <= we_count + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] ref_mem [256];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock_write);
    @(negedge clock_write);
  endtask

  task automatic set_r0(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] data);
    r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = data;
  endtask

  task automatic set_r1(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] data);
    r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = data;
  endtask

  task automatic do_reset(input logic init);
    reset = 1'b1; init_en = init;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick; tick;
    reset = 1'b0; init_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; init_en = 1'b1;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock_write);
    tick; tick;
    #1;
    n_checks++; if ({r1_gnt, r0_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b%b expected 00", r1_gnt, r0_gnt); else n_pass++;
    n_checks++; if ({r1_rvalid, r0_rvalid, r1_err, ram_we} !== 4'b0000) $display("FAIL rst_pulses: got %b expected 0000", {r1_rvalid, r0_rvalid, r1_err, ram_we}); else n_pass++;
    n_checks++; if ({r1_rdata, r0_rdata} !== 16'h0000) $display("FAIL rst_rdata: got %h expected 0000", {r1_rdata, r0_rdata}); else n_pass++;
    n_checks++; if (state_o !== IDLE) $display("FAIL rst_state: got %0d expected %0d", state_o, IDLE); else n_pass++;
    reset = 1'b0; init_en = 1'b0;
    tick; #1;
    n_checks++; if ({r1_gnt, r0_gnt} !== 2'b00) $display("FAIL rst_idle_gnt: got %b%b expected 00", r1_gnt, r0_gnt); else n_pass++;
  endtask

  task automatic test_single_read;
    set_r0(1'b1, 1'b0, 8'h05, 8'h00);
    #1;
    n_checks++; if (r0_gnt !== 1'b0) $display("FAIL rd_nogrant_yet: got %b expected 0", r0_gnt); else n_pass++;
    tick; #1;
    n_checks++; if (r0_gnt !== 1'b1) $display("FAIL rd_gnt: got %b expected 1", r0_gnt); else n_pass++;
    n_checks++; if (ram_addr_read !== 8'h05) $display("FAIL rd_addr: got %h expected 05", ram_addr_read); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rd_no_we: got %b expected 0", ram_we); else n_pass++;
    tick;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if (r0_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b expected 1", r0_rvalid); else n_pass++;
    n_checks++; if (r0_rdata !== 8'h3C) $display("FAIL rd_rdata: got %h expected 3c", r0_rdata); else n_pass++;
    n_checks++; if ({r1_gnt, r1_rvalid, r1_err} !== 3'b000) $display("FAIL rd_r1_quiet: got %b expected 000", {r1_gnt, r1_rvalid, r1_err}); else n_pass++;
    tick; #1;
    n_checks++; if ({r0_rvalid, r0_gnt} !== 2'b00) $display("FAIL rd_pulse_end: got %b expected 00", {r0_rvalid, r0_gnt}); else n_pass++;
  endtask

  task automatic test_round_robin;
    int own, prev;
    do_reset(1'b0);
    set_r0(1'b1, 1'b0, 8'h10, 8'h00);
    set_r1(1'b1, 1'b0, 8'h11, 8'h00);
    #1;
    n_checks++; if ({r1_gnt, r0_gnt} !== 2'b00) $display("FAIL rr_idle: got %b%b expected 00", r1_gnt, r0_gnt); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick; #1;
      own  = (i / MB) % 2;
      prev = (i >= 1) ? ((i - 1) / MB) % 2 : -1;
      n_checks++; if ({r1_gnt, r0_gnt} !== {own == 1, own == 0}) $display("FAIL rr_gnt[%0d]: got %b%b expected %b%b", i, r1_gnt, r0_gnt, own == 1, own == 0); else n_pass++;
      n_checks++; if ({r1_rvalid, r0_rvalid} !== {prev == 1, prev == 0}) $display("FAIL rr_rvalid[%0d]: got %b%b expected %b%b", i, r1_rvalid, r0_rvalid, prev == 1, prev == 0); else n_pass++;
    end
    n_checks++; if ({r1_rdata, r0_rdata} !== {init_val(8'h11), init_val(8'h10)}) $display("FAIL rr_rdata: got %h expected %h", {r1_rdata, r0_rdata}, {init_val(8'h11), init_val(8'h10)}); else n_pass++;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick; tick;
  endtask

  task automatic test_write_then_read;
    int base;
    base = we_count;
    set_r1(1'b1, 1'b1, 8'h20, 8'hA5);
    #1;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL wr_pre_we: got %b expected 0", ram_we); else n_pass++;
    tick; #1;
    n_checks++; if ({r1_gnt, ram_we} !== 2'b11) $display("FAIL wr_gnt_we: got %b expected 11", {r1_gnt, ram_we}); else n_pass++;
    n_checks++; if ({ram_addr_write, ram_data_write} !== 16'h20A5) $display("FAIL wr_port: got %h expected 20a5", {ram_addr_write, ram_data_write}); else n_pass++;
    tick;
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    set_r0(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    n_checks++; if ({ram_we, r1_rvalid} !== 2'b00) $display("FAIL wr_after: got %b expected 00", {ram_we, r1_rvalid}); else n_pass++;
    tick; #1;
    n_checks++; if ({r0_gnt, ram_addr_read} !== {1'b1, 8'h20}) $display("FAIL wr_rd_gnt: got %b %h expected 1 20", r0_gnt, ram_addr_read); else n_pass++;
    tick;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if ({r0_rvalid, r0_rdata} !== {1'b1, 8'hA5}) $display("FAIL wr_rd_data: got %b %h expected 1 a5", r0_rvalid, r0_rdata); else n_pass++;
    n_checks++; if (we_count - base !== 1) $display("FAIL wr_we_pulses: got %0d expected 1", we_count - base); else n_pass++;
    tick;
  endtask

  task automatic test_drop;
    set_r0(1'b1, 1'b0, 8'h01, 8'h00);
    tick;
    set_r0(1'b0, 1'b0, 8'h01, 8'h00);
    set_r1(1'b1, 1'b1, 8'h40, 8'h77);
    #1;
    n_checks++; if ({r0_gnt, ram_we} !== 2'b10) $display("FAIL drop_cycle: got %b expected 10", {r0_gnt, ram_we}); else n_pass++;
    tick; #1;
    n_checks++; if ({r1_gnt, r0_gnt, r0_rvalid} !== 3'b100) $display("FAIL drop_switch: got %b expected 100", {r1_gnt, r0_gnt, r0_rvalid}); else n_pass++;
    n_checks++; if ({ram_we, ram_addr_write} !== {1'b1, 8'h40}) $display("FAIL drop_r1_write: got %b %h expected 1 40", ram_we, ram_addr_write); else n_pass++;
    tick;
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL drop_we_end: got %b expected 0", ram_we); else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid;
    set_r1(1'b1, 1'b1, 8'h30, 8'h99);
    tick;
    reset = 1'b1;
    #1;
    n_checks++; if ({r1_gnt, ram_we} !== 2'b10) $display("FAIL rmid_we: got %b expected 10", {r1_gnt, ram_we}); else n_pass++;
    tick;
    reset = 1'b0;
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if ({r1_gnt, r0_gnt, r1_rvalid} !== 3'b000) $display("FAIL rmid_gnt: got %b expected 000", {r1_gnt, r0_gnt, r1_rvalid}); else n_pass++;
    n_checks++; if (state_o !== IDLE) $display("FAIL rmid_state: got %0d expected %0d", state_o, IDLE); else n_pass++;
    n_checks++; if (ram[8'h30] !== init_val(8'h30)) $display("FAIL rmid_mem: got %h expected %h", ram[8'h30], init_val(8'h30)); else n_pass++;
    set_r0(1'b1, 1'b0, 8'h05, 8'h00);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if ({r0_rvalid, r0_gnt} !== 2'b00) $display("FAIL rmid_no_rvalid: got %b expected 00", {r0_rvalid, r0_gnt}); else n_pass++;
    tick;
  endtask

  task automatic test_protect;
    set_r1(1'b1, 1'b1, 8'h03, 8'hFF);
    tick; #1;
    n_checks++; if ({r1_gnt, ram_we} !== {1'b1, ~WP}) $display("FAIL wp_r1_we: got %b expected %b", {r1_gnt, ram_we}, {1'b1, ~WP}); else n_pass++;
    tick;
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if (r1_err !== WP) $display("FAIL wp_err: got %b expected %b", r1_err, WP); else n_pass++;
    tick; #1;
    n_checks++; if (r1_err !== 1'b0) $display("FAIL wp_err_end: got %b expected 0", r1_err); else n_pass++;
    n_checks++; if (ram[8'h03] !== (WP ? init_val(8'h03) : 8'hFF)) $display("FAIL wp_mem: got %h expected %h", ram[8'h03], WP ? init_val(8'h03) : 8'hFF); else n_pass++;
    set_r0(1'b1, 1'b1, 8'h03, 8'hFF);
    tick; #1;
    n_checks++; if ({r0_gnt, ram_we} !== 2'b11) $display("FAIL wp_r0_we: got %b expected 11", {r0_gnt, ram_we}); else n_pass++;
    tick;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    n_checks++; if (ram[8'h03] !== 8'hFF) $display("FAIL wp_r0_mem: got %h expected ff", ram[8'h03]); else n_pass++;
    tick;
  endtask

  task automatic test_random;
    bit         act [2];
    logic       t_we [2];
    logic [7:0] t_addr [2];
    logic [7:0] t_wd [2];
    bit         exp_rv [2];
    bit         exp_err;
    bit         rq [2];
    bit         hs [2];
    bit         prot;
    bit         exp_we;
    logic [7:0] exp_d;
    int         own, cnt, last;

    do_reset(1'b1);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    exp_q0.delete(); exp_q1.delete();
    own = -1; cnt = 0; last = 1;
    act[0] = 0; act[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0; exp_err = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && cyc < 1480 && $urandom_range(0, 99) < 60) begin
          act[k]    = 1;
          t_we[k]   = 1'($urandom_range(0, 1));
          t_addr[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
          t_wd[k]   = 8'($urandom_range(0, 255));
        end
      end
      set_r0(act[0], t_we[0], t_addr[0], t_wd[0]);
      set_r1(act[1], t_we[1], t_addr[1], t_wd[1]);
      #1;

      // expectations for this cycle
      hs[0]  = act[0] && own == 0;
      hs[1]  = act[1] && own == 1;
      prot   = WP && hs[1] && t_we[1] && t_addr[1] < PROT;
      exp_we = (hs[0] && t_we[0]) || (hs[1] && t_we[1] && !prot);

      n_checks++; if ({r1_gnt, r0_gnt} !== {own == 1, own == 0}) $display("FAIL rnd_gnt cyc=%0d: got %b%b expected %b%b", cyc, r1_gnt, r0_gnt, own == 1, own == 0); else n_pass++;
      n_checks++; if (ram_we !== exp_we) $display("FAIL rnd_we cyc=%0d: got %b expected %b", cyc, ram_we, exp_we); else n_pass++;
      if (exp_we) begin
        n_checks++; if ({ram_addr_write, ram_data_write} !== (hs[1] ? {t_addr[1], t_wd[1]} : {t_addr[0], t_wd[0]})) $display("FAIL rnd_wport cyc=%0d: got %h", cyc, {ram_addr_write, ram_data_write}); else n_pass++;
      end
      if ((hs[0] && !t_we[0]) || (hs[1] && !t_we[1])) begin
        n_checks++; if (ram_addr_read !== (hs[1] ? t_addr[1] : t_addr[0])) $display("FAIL rnd_raddr cyc=%0d: got %h expected %h", cyc, ram_addr_read, hs[1] ? t_addr[1] : t_addr[0]); else n_pass++;
      end
      n_checks++; if ({r1_rvalid, r0_rvalid} !== {exp_rv[1], exp_rv[0]}) $display("FAIL rnd_rvalid cyc=%0d: got %b%b expected %b%b", cyc, r1_rvalid, r0_rvalid, exp_rv[1], exp_rv[0]); else n_pass++;
      if (exp_rv[0] && exp_q0.size() > 0) begin
        exp_d = exp_q0.pop_front();
        n_checks++; if (r0_rdata !== exp_d) $display("FAIL rnd_rdata0 cyc=%0d: got %h expected %h", cyc, r0_rdata, exp_d); else n_pass++;
      end
      if (exp_rv[1] && exp_q1.size() > 0) begin
        exp_d = exp_q1.pop_front();
        n_checks++; if (r1_rdata !== exp_d) $display("FAIL rnd_rdata1 cyc=%0d: got %h expected %h", cyc, r1_rdata, exp_d); else n_pass++;
      end
      n_checks++; if (r1_err !== exp_err) $display("FAIL rnd_err cyc=%0d: got %b expected %b", cyc, r1_err, exp_err); else n_pass++;

      // advance the reference model by one cycle
      rq[0] = act[0]; rq[1] = act[1];
      exp_rv[0] = 0; exp_rv[1] = 0;
      exp_err = prot;
      for (int k = 0; k < 2; k++) begin
        if (hs[k]) begin
          if (t_we[k]) begin
            if (!(k == 1 && prot)) ref_mem[t_addr[k]] = t_wd[k];
          end else begin
            exp_rv[k] = 1;
            if (k == 0) exp_q0.push_back(ref_mem[t_addr[k]]);
            else        exp_q1.push_back(ref_mem[t_addr[k]]);
          end
          act[k] = 0;
        end
      end
      if (own < 0) begin
        if (rq[0] && rq[1]) own = 1 - last;
        else if (rq[0])     own = 0;
        else if (rq[1])     own = 1;
        if (own >= 0) begin cnt = 0; last = own; end
      end else if (!rq[own]) begin
        own = rq[1 - own] ? 1 - own : -1;
        if (own >= 0) begin cnt = 0; last = own; end
      end else begin
        cnt++;
        if (rq[1 - own] && cnt >= MB) begin
          own = 1 - own; cnt = 0; last = own;
        end
      end
      tick;
    end
    n_checks++; if (exp_q0.size() + exp_q1.size() !== 0) $display("FAIL rnd_drain: %0d reads never returned", exp_q0.size() + exp_q1.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    init_en = 1'b1;
    set_r0(1'b0, 1'b0, 8'h00, 8'h00);
    set_r1(1'b0, 1'b0, 8'h00, 8'h00);
    test_reset;
    test_single_read;
    test_round_robin;
    test_write_then_read;
    test_drop;
    test_reset_mid;
    test_protect;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
